// File: rtl/ntsc_timing_sequencer_if.sv
// NTSC timing sequencer control/timing bundle.
// Master is the sequencer; slave is the consumer (encoder, pixel source).
interface ntsc_timing_sequencer_if;
    logic        enable;
    logic        color_en;
    logic [1:0]  level_sel;
    logic        pix_req;
    logic [10:0] hcount;
    logic [8:0]  vcount;
    logic        line_start;
    logic        field_start;
    logic [2:0]  sc_phase;
    logic        running;

    modport master (
        input  enable,
        input  color_en,
        output level_sel,
        output pix_req,
        output hcount,
        output vcount,
        output line_start,
        output field_start,
        output sc_phase,
        output running
    );

    modport slave (
        output enable,
        output color_en,
        input  level_sel,
        input  pix_req,
        input  hcount,
        input  vcount,
        input  line_start,
        input  field_start,
        input  sc_phase,
        input  running
    );
endinterface

// File: rtl/ntsc_timing_sequencer.sv
// NTSC line/field timing sequencer at 8x subcarrier.
// Owns h/v counters and selects the DAC level; starts/stops on field edges.
module ntsc_timing_sequencer #(
    parameter int H_TOTAL      = 1820,
    parameter int H_SYNC       = 134,
    parameter int BURST_START  = 152,
    parameter int BURST_LEN    = 72,
    parameter int H_ACT_START  = 300,
    parameter int H_ACT_LEN    = 1480,
    parameter int V_TOTAL      = 262,
    parameter int V_BLANK      = 20,
    parameter int V_SYNC_START = 3,
    parameter int V_SYNC_LEN   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    ntsc_timing_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    localparam logic [1:0] LVL_SYNC   = 2'b00;
    localparam logic [1:0] LVL_BLANK  = 2'b01;
    localparam logic [1:0] LVL_BURST  = 2'b10;
    localparam logic [1:0] LVL_ACTIVE = 2'b11;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_SYNC_W = 11'(H_SYNC);
    localparam logic [10:0] H_VS_END = 11'(H_TOTAL - H_SYNC);
    localparam logic [10:0] BURST_LO = 11'(BURST_START);
    localparam logic [10:0] BURST_HI = 11'(BURST_START + BURST_LEN);
    localparam logic [10:0] ACT_LO   = 11'(H_ACT_START);
    localparam logic [10:0] ACT_HI   = 11'(H_ACT_START + H_ACT_LEN);
    localparam logic [10:0] PIX_LO   = 11'(H_ACT_START - 1);
    localparam logic [10:0] PIX_HI   = 11'(H_ACT_START + H_ACT_LEN - 1);
    localparam logic [8:0]  V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0]  V_VIS    = 9'(V_BLANK);
    localparam logic [8:0]  VS_LO    = 9'(V_SYNC_START);
    localparam logic [8:0]  VS_HI    = 9'(V_SYNC_START + V_SYNC_LEN);

    state_t      state_q, state_d;
    logic [10:0] hcount_q, hcount_d;
    logic [8:0]  vcount_q, vcount_d;
    logic [1:0]  level_q, level_d;
    logic        pix_req_q, pix_req_d;
    logic        line_start_q, line_start_d;
    logic        field_start_q, field_start_d;
    logic [2:0]  sc_phase_q, sc_phase_d;
    logic        running_q, running_d;
    logic        color_lat_q, color_lat_d;

    logic field_end;
    logic vsync_line;
    logic visible;
    logic in_burst;
    logic in_act;
    logic in_pix;

    assign field_end = (hcount_q == H_LAST) && (vcount_q == V_LAST);

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            hcount_q      <= '0;
            vcount_q      <= '0;
            level_q       <= LVL_BLANK;
            pix_req_q     <= 1'b0;
            line_start_q  <= 1'b0;
            field_start_q <= 1'b0;
            sc_phase_q    <= '0;
            running_q     <= 1'b0;
            color_lat_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            level_q       <= level_d;
            pix_req_q     <= pix_req_d;
            line_start_q  <= line_start_d;
            field_start_q <= field_start_d;
            sc_phase_q    <= sc_phase_d;
            running_q     <= running_d;
            color_lat_q   <= color_lat_d;
        end
    end

    // Next state: start on enable, drain to the field end once it drops
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.enable) state_d = S_RUN;
            end
            S_RUN: begin
                if (!bus.enable) state_d = S_STOPPING;
            end
            S_STOPPING: begin
                if (bus.enable) state_d = S_RUN;
                else if (field_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counters advance while running; IDLE and field exit park them at 0
    always_comb begin
        hcount_d = '0;
        vcount_d = '0;
        if (state_q != S_IDLE && state_d != S_IDLE) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 9'd1;
            end else begin
                hcount_d = hcount_q + 11'd1;
                vcount_d = vcount_q;
            end
        end
    end

    // Output decode from next-cycle counters so flops match hcount/vcount
    always_comb begin
        vsync_line    = (vcount_d >= VS_LO) && (vcount_d < VS_HI);
        visible       = (vcount_d >= V_VIS);
        in_burst      = (hcount_d >= BURST_LO) && (hcount_d < BURST_HI);
        in_act        = (hcount_d >= ACT_LO) && (hcount_d < ACT_HI);
        in_pix        = (hcount_d >= PIX_LO) && (hcount_d < PIX_HI);
        level_d       = LVL_BLANK;
        pix_req_d     = 1'b0;
        line_start_d  = 1'b0;
        field_start_d = 1'b0;
        running_d     = (state_d != S_IDLE);
        sc_phase_d    = sc_phase_q + 3'd1;
        color_lat_d   = field_start_q ? bus.color_en : color_lat_q;
        if (state_d != S_IDLE) begin
            line_start_d  = (hcount_d == '0);
            field_start_d = (hcount_d == '0) && (vcount_d == '0);
            if (vsync_line) begin
                level_d = (hcount_d < H_VS_END) ? LVL_SYNC : LVL_BLANK;
            end else begin
                pix_req_d = visible && in_pix;
                if (hcount_d < H_SYNC_W) level_d = LVL_SYNC;
                else if (in_burst && color_lat_q) level_d = LVL_BURST;
                else if (in_act && visible) level_d = LVL_ACTIVE;
                else level_d = LVL_BLANK;
            end
        end
    end

    assign bus.level_sel   = level_q;
    assign bus.pix_req     = pix_req_q;
    assign bus.hcount      = hcount_q;
    assign bus.vcount      = vcount_q;
    assign bus.line_start  = line_start_q;
    assign bus.field_start = field_start_q;
    assign bus.sc_phase    = sc_phase_q;
    assign bus.running     = running_q;

endmodule

// File: tb/tb_ntsc_timing_sequencer.sv
// Bench for ntsc_timing_sequencer on a scaled-down raster.
// Cycle model feeds a scoreboard; feature tasks add targeted checks.
module tb_ntsc_timing_sequencer;

    localparam int HT    = 92;
    localparam int HS    = 7;
    localparam int BS    = 9;
    localparam int BL    = 8;
    localparam int AS    = 20;
    localparam int AL    = 68;
    localparam int VT    = 30;
    localparam int VB    = 8;
    localparam int VSS   = 3;
    localparam int VSL   = 3;
    localparam int FIELD = HT * VT;
    localparam int LIMIT = 2 * FIELD + 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ntsc_timing_sequencer_if bus ();

    ntsc_timing_sequencer #(
        .H_TOTAL(HT), .H_SYNC(HS), .BURST_START(BS), .BURST_LEN(BL),
        .H_ACT_START(AS), .H_ACT_LEN(AL), .V_TOTAL(VT), .V_BLANK(VB),
        .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic        run;
        logic [1:0]  lvl;
        logic        pix;
        logic [10:0] h;
        logic [8:0]  v;
        logic        ls;
        logic        fs;
        logic [2:0]  ph;
    } obs_t;

    obs_t sbq[$];
    int tests_run = 0;
    int tests_failed = 0;
    int sb_prints = 0;
    int act_in_vblank = 0;
    logic cur_en = 1'b0;
    logic cur_ce = 1'b0;

    int   m_state = 0;
    int   m_h = 0;
    int   m_v = 0;
    int   m_ph = 0;
    logic m_col = 1'b0;

    function automatic obs_t sample();
        obs_t o;
        o.run = bus.running;
        o.lvl = bus.level_sel;
        o.pix = bus.pix_req;
        o.h   = bus.hcount;
        o.v   = bus.vcount;
        o.ls  = bus.line_start;
        o.fs  = bus.field_start;
        o.ph  = bus.sc_phase;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        logic vs;
        o.run = (m_state != 0);
        o.h   = 11'(m_h);
        o.v   = 9'(m_v);
        o.ph  = 3'(m_ph);
        o.lvl = 2'b01;
        o.pix = 1'b0;
        o.ls  = 1'b0;
        o.fs  = 1'b0;
        if (m_state != 0) begin
            vs = (m_v >= VSS) && (m_v < VSS + VSL);
            o.ls = (m_h == 0);
            o.fs = (m_h == 0) && (m_v == 0);
            if (vs) o.lvl = (m_h < HT - HS) ? 2'b00 : 2'b01;
            else if (m_h < HS) o.lvl = 2'b00;
            else if (m_col && m_h >= BS && m_h < BS + BL) o.lvl = 2'b10;
            else if (m_v >= VB && m_h >= AS && m_h < AS + AL) o.lvl = 2'b11;
            if (!vs && m_v >= VB && m_h + 1 >= AS && m_h + 1 < AS + AL)
                o.pix = 1'b1;
        end
        return o;
    endfunction

    task automatic model_advance(input logic en, input logic ce, input logic r);
        if (r) begin
            m_state = 0; m_h = 0; m_v = 0; m_ph = 0; m_col = 1'b0;
        end else begin
            if (m_state != 0 && m_h == 0 && m_v == 0) m_col = ce;
            m_ph = (m_ph + 1) % 8;
            if (m_state == 0) begin
                if (en) m_state = 1;
            end else if (m_state == 2 && !en && m_h == HT - 1 && m_v == VT - 1) begin
                m_state = 0; m_h = 0; m_v = 0;
            end else begin
                m_state = en ? 1 : 2;
                m_h++;
                if (m_h == HT) begin
                    m_h = 0;
                    m_v++;
                    if (m_v == VT) m_v = 0;
                end
            end
        end
    endtask

    task automatic step(input logic en, input logic ce, input logic r);
        obs_t got;
        obs_t exp;
        rst = r;
        bus.enable = en;
        bus.color_en = ce;
        @(posedge clk);
        model_advance(en, ce, r);
        sbq.push_back(model_obs());
        #1;
        got = sample();
        exp = sbq.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            if (sb_prints < 10) begin
                sb_prints++;
                $display("FAIL scoreboard h=%0d v=%0d: got %h, expected %h",
                         m_h, m_v, got, exp);
            end
        end
        if (got.lvl == 2'b11 && int'(got.v) < VB) act_in_vblank++;
    endtask

    task automatic tick();
        step(cur_en, cur_ce, 1'b0);
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(int'(bus.hcount) == h && int'(bus.vcount) == v && bus.running)
               && n < LIMIT) begin
            tick();
            n++;
        end
        tests_run++;
        if (n >= LIMIT) begin
            tests_failed++;
            $display("FAIL run_to(%0d,%0d): reached h=%0d v=%0d", h, v,
                     bus.hcount, bus.vcount);
        end
    endtask

    task automatic test_reset();
        int busy = 0;
        cur_en = 1'b0;
        cur_ce = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b1);
        tests_run++;
        if (bus.running !== 1'b0 || bus.level_sel !== 2'b01 ||
            bus.hcount !== 11'd0 || bus.vcount !== 9'd0 ||
            bus.pix_req !== 1'b0 || bus.line_start !== 1'b0 ||
            bus.field_start !== 1'b0 || bus.sc_phase !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_values: got %h, expected run=0 lvl=01 rest 0",
                     sample());
        end
        repeat (5) begin
            tick();
            if (bus.running !== 1'b0 || bus.hcount !== 11'd0) busy++;
        end
        tests_run++;
        if (busy != 0) begin
            tests_failed++;
            $display("FAIL idle_hold: %0d busy cycles, expected 0", busy);
        end
    endtask

    task automatic test_start();
        int sync_cnt = 0;
        cur_en = 1'b1;
        cur_ce = 1'b1;
        tick();
        tests_run++;
        if (bus.field_start !== 1'b1 || bus.hcount !== 11'd0 ||
            bus.vcount !== 9'd0 || bus.level_sel !== 2'b00 ||
            bus.running !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_latency: got %h, expected fs=1 h=0 v=0 lvl=00",
                     sample());
        end
        if (bus.level_sel === 2'b00) sync_cnt++;
        repeat (HS - 1) begin
            tick();
            if (bus.level_sel === 2'b00) sync_cnt++;
        end
        tick();
        tests_run++;
        if (sync_cnt != HS || bus.level_sel !== 2'b01) begin
            tests_failed++;
            $display("FAIL hsync_width: got %0d sync then lvl %b, expected %0d then 01",
                     sync_cnt, bus.level_sel, HS);
        end
    endtask

    task automatic test_vsync();
        int s = 0;
        int b = 0;
        int p = 0;
        int first_b = -1;
        run_to(0, VSS);
        for (int i = 0; i < VSL * HT; i++) begin
            if (i != 0) tick();
            if (bus.level_sel === 2'b00) s++;
            if (bus.level_sel === 2'b01) begin
                b++;
                if (first_b < 0) first_b = int'(bus.hcount);
            end
            if (bus.pix_req === 1'b1) p++;
        end
        tests_run++;
        if (s != VSL * (HT - HS) || b != VSL * HS || p != 0 ||
            first_b != HT - HS) begin
            tests_failed++;
            $display("FAIL vsync_lines: sync=%0d blank=%0d pix=%0d fb=%0d, expected %0d %0d 0 %0d",
                     s, b, p, first_b, VSL * (HT - HS), VSL * HS, HT - HS);
        end
    endtask

    task automatic test_visible_line();
        int pf = -1, pl = -1, pc = 0;
        int af = -1, al = -1, ac = 0;
        int bf = -1, bc = 0, tail = 0;
        int h;
        run_to(0, VB);
        for (int i = 0; i < HT; i++) begin
            if (i != 0) tick();
            h = int'(bus.hcount);
            if (bus.pix_req === 1'b1) begin
                if (pf < 0) pf = h;
                pl = h;
                pc++;
            end
            if (bus.level_sel === 2'b11) begin
                if (af < 0) af = h;
                al = h;
                ac++;
            end
            if (bus.level_sel === 2'b10) begin
                if (bf < 0) bf = h;
                bc++;
            end
            if (h >= AS + AL && bus.level_sel === 2'b01) tail++;
        end
        tests_run++;
        if (pf != AS - 1 || pl != AS + AL - 2 || pc != AL) begin
            tests_failed++;
            $display("FAIL pix_window: got %0d..%0d n=%0d, expected %0d..%0d n=%0d",
                     pf, pl, pc, AS - 1, AS + AL - 2, AL);
        end
        tests_run++;
        if (af != AS || al != AS + AL - 1 || ac != AL) begin
            tests_failed++;
            $display("FAIL active_window: got %0d..%0d n=%0d, expected %0d..%0d n=%0d",
                     af, al, ac, AS, AS + AL - 1, AL);
        end
        tests_run++;
        if (bf != BS || bc != BL || tail != HT - AS - AL) begin
            tests_failed++;
            $display("FAIL burst_tail: burst %0d n=%0d tail=%0d, expected %0d n=%0d tail=%0d",
                     bf, bc, tail, BS, BL, HT - AS - AL);
        end
        tests_run++;
        if (act_in_vblank != 0) begin
            tests_failed++;
            $display("FAIL vblank_active: got %0d ACTIVE cycles, expected 0",
                     act_in_vblank);
        end
    endtask

    task automatic test_color_gate();
        int bc0 = 0;
        int bc1 = 0;
        int n = 0;
        int p1 = -1;
        int p2 = -1;
        step(1'b0, 1'b0, 1'b1);
        cur_en = 1'b1;
        cur_ce = 1'b0;
        tick();
        run_to(0, 15);
        cur_ce = 1'b1;
        while (!(bus.hcount == 11'd0 && bus.vcount == 9'd0) && n < LIMIT) begin
            if (bus.level_sel === 2'b10) bc0++;
            tick();
            n++;
        end
        tests_run++;
        if (bc0 != 0) begin
            tests_failed++;
            $display("FAIL color_hold: got %0d burst cycles, expected 0", bc0);
        end
        for (int i = 0; i < FIELD; i++) begin
            if (i != 0) tick();
            if (bus.level_sel === 2'b10) bc1++;
            if (int'(bus.hcount) == BS && int'(bus.vcount) == VB)
                p1 = int'(bus.sc_phase);
            if (int'(bus.hcount) == BS && int'(bus.vcount) == VB + 1)
                p2 = int'(bus.sc_phase);
        end
        tests_run++;
        if (bc1 != (VT - VSL) * BL) begin
            tests_failed++;
            $display("FAIL color_next_field: got %0d burst cycles, expected %0d",
                     bc1, (VT - VSL) * BL);
        end
        tests_run++;
        if (p1 < 0 || p2 < 0 || ((p2 - p1 + 8) % 8) != 4) begin
            tests_failed++;
            $display("FAIL burst_phase: got %0d then %0d, expected difference 4",
                     p1, p2);
        end
    endtask

    task automatic test_stop();
        int n = 0;
        int ph = -1;
        int pv = -1;
        int idle_busy = 0;
        cur_en = 1'b1;
        run_to(0, 12);
        cur_en = 1'b0;
        while (bus.running === 1'b1 && n < LIMIT) begin
            ph = int'(bus.hcount);
            pv = int'(bus.vcount);
            tick();
            n++;
        end
        tests_run++;
        if (n != (VT - 12) * HT || ph != HT - 1 || pv != VT - 1) begin
            tests_failed++;
            $display("FAIL stop_field_end: %0d cycles, last h=%0d v=%0d, expected %0d %0d %0d",
                     n, ph, pv, (VT - 12) * HT, HT - 1, VT - 1);
        end
        tests_run++;
        if (bus.level_sel !== 2'b01 || bus.hcount !== 11'd0 ||
            bus.pix_req !== 1'b0 || bus.field_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL stop_idle: got %h, expected lvl=01 h=0 pix=0 fs=0",
                     sample());
        end
        repeat (4) begin
            tick();
            if (bus.running !== 1'b0) idle_busy++;
        end
        tests_run++;
        if (idle_busy != 0) begin
            tests_failed++;
            $display("FAIL stop_stays_idle: got %0d running cycles, expected 0",
                     idle_busy);
        end
    endtask

    task automatic test_glitch();
        int breaks = 0;
        int prev;
        cur_en = 1'b1;
        tick();
        run_to(40, 7);
        prev = int'(bus.hcount);
        step(1'b0, cur_ce, 1'b0);
        if (int'(bus.hcount) != prev + 1 || bus.running !== 1'b1) breaks++;
        prev = int'(bus.hcount);
        repeat (3) begin
            tick();
            if (int'(bus.hcount) != prev + 1 || bus.running !== 1'b1) breaks++;
            prev = int'(bus.hcount);
        end
        tests_run++;
        if (breaks != 0 || prev != 44) begin
            tests_failed++;
            $display("FAIL glitch_continuity: %0d breaks, h=%0d, expected 0 and 44",
                     breaks, prev);
        end
    endtask

    task automatic test_rst_mid();
        int busy = 0;
        run_to(50, 15);
        step(1'b1, cur_ce, 1'b1);
        tests_run++;
        if (bus.running !== 1'b0 || bus.level_sel !== 2'b01 ||
            bus.hcount !== 11'd0 || bus.vcount !== 9'd0 ||
            bus.pix_req !== 1'b0 || bus.line_start !== 1'b0 ||
            bus.field_start !== 1'b0 || bus.sc_phase !== 3'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_field: got %h, expected reset values", sample());
        end
        cur_en = 1'b0;
        repeat (10) begin
            tick();
            if (bus.running !== 1'b0) busy++;
        end
        cur_en = 1'b1;
        tick();
        tests_run++;
        if (busy != 0 || bus.running !== 1'b1 || bus.field_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_restart: busy=%0d run=%b fs=%b, expected 0 1 1",
                     busy, bus.running, bus.field_start);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.color_en = 1'b0;
        test_reset();
        test_start();
        test_vsync();
        test_visible_line();
        test_color_gate();
        test_stop();
        test_glitch();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
